// File: rtl/recur_seq.sv
// recur_seq: register-file recurrence generator r[i] = r[i-1] op r[i-2], one term per clock.
// Define RECUR_OVF_EN to build the sticky signed-overflow detector for ADD/SUB terms.
module recur_seq #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  seed0,
    input  logic [WIDTH-1:0]  seed1,
    input  logic [ADDR_W:0]   count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic [1:0]        state,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] prev1, prev2, s1, alu, nxt;
    logic [2:0]       op_q;
    logic [ADDR_W:0]  cnt_q, idx;
    logic             last;

    // prev1/prev2 mirror r[i-1]/r[i-2], so the file is never read on the write path
    always_comb begin
        alu  = op_q == 3'b001 ? prev1 - prev2 :
               op_q == 3'b010 ? prev1 & prev2 :
               op_q == 3'b011 ? prev1 | prev2 :
               op_q == 3'b100 ? prev1 ^ prev2 : prev1 + prev2;
        nxt  = idx == ONE ? s1 : alu;
        last = idx == cnt_q - ONE;
    end

    assign rd_data = mem[rd_addr];
    assign busy    = state != IDLE;
    assign done    = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= '0;
            cnt_q <= '0;
            idx   <= '0;
            prev1 <= '0;
            prev2 <= '0;
            s1    <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    cnt_q <= count;
                    s1    <= seed1;
                    prev1 <= seed0;
                    idx   <= ONE;
                    if (|count) mem[0] <= seed0;
                    state <= count > ONE ? RUN : DONE;
                end
                RUN: begin
                    mem[idx[ADDR_W-1:0]] <= nxt;
                    prev2 <= prev1;
                    prev1 <= nxt;
                    idx   <= idx + ONE;
                    if (last) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RECUR_OVF_EN
    logic ovf, ovf_hit;
    // SUB flags when operand signs differ, ADD (and the 101-111 aliases) when they match
    always_comb
        ovf_hit = op_q == 3'b001 ? (prev1[WIDTH-1] != prev2[WIDTH-1]) && (alu[WIDTH-1] != prev1[WIDTH-1]) :
                  (op_q == 3'b000 || op_q[2:1] == 2'b11 || op_q == 3'b101) ?
                  (prev1[WIDTH-1] == prev2[WIDTH-1]) && (alu[WIDTH-1] != prev1[WIDTH-1]) : 1'b0;
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (state == IDLE && start)
            ovf <= 1'b0;
        else if (state == RUN && idx != ONE && ovf_hit)
            ovf <= 1'b1;
    end
    assign overflow = ovf;
`else
    assign overflow = 1'b0;
`endif
endmodule
